// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter: merges the arith and mul_div result streams into one register-file
// write port. mul_div always wins; colliding arith results wait in an in-order FIFO.
module scalar_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            kill_i,
    input  logic                            arith_valid_i,
    input  logic [4:0]                      arith_rd_i,
    input  logic [XLEN-1:0]                 arith_result_i,
    input  logic                            mul_div_valid_i,
    input  logic [4:0]                      mul_div_rd_i,
    input  logic [XLEN-1:0]                 mul_div_result_i,
    output logic                            stall_o,
    output logic                            wb_valid_o,
    output logic                            wb_we_o,
    output logic [4:0]                      wb_rd_o,
    output logic [XLEN-1:0]                 wb_result_o,
    output logic                            wb_src_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  data_mem_q [FIFO_DEPTH];
    logic [4:0]       rd_mem_q   [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic             wb_src_q, wb_src_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_result_q, wb_result_d;

    logic full, empty, push, pop;

    always_comb begin
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        empty       = (count_q == '0);
        pop         = 1'b0;
        wb_valid_d  = 1'b0;
        wb_src_d    = 1'b0;
        wb_rd_d     = '0;
        wb_result_d = '0;

        // Priority: mul_div (cannot wait) > buffered arith > bypassed arith.
        if (mul_div_valid_i) begin
            wb_valid_d  = 1'b1;
            wb_src_d    = 1'b1;
            wb_rd_d     = mul_div_rd_i;
            wb_result_d = mul_div_result_i;
        end else if (!empty) begin
            pop         = 1'b1;
            wb_valid_d  = 1'b1;
            wb_rd_d     = rd_mem_q[rd_ptr_q];
            wb_result_d = data_mem_q[rd_ptr_q];
        end else if (arith_valid_i) begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = arith_rd_i;
            wb_result_d = arith_result_i;
        end

        // An arith that lost arbitration is queued unless the FIFO is full (then dropped).
        push = arith_valid_i && !full && (mul_div_valid_i || !empty);

        overflow_d = overflow_q | (arith_valid_i & full & ~kill_i);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (kill_i) begin
            push        = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            wb_valid_d  = 1'b0;
            wb_src_d    = 1'b0;
            wb_rd_d     = '0;
            wb_result_d = '0;
        end

        wb_we_d = wb_valid_d && (wb_rd_d != 5'd0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_src_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_src_q    <= wb_src_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
        end
    end

    // Storage needs no reset: occupancy is governed solely by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= arith_result_i;
            rd_mem_q[wr_ptr_q]   <= arith_rd_i;
        end
    end

    assign stall_o      = full;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_src_o     = wb_src_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_result_o  = wb_result_q;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: directed table (DEPTH=2), reset corner cases, and a
// scoreboard soak on DEPTH=2 and DEPTH=4 instances.
module tb_scalar_wb_arbiter;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            av [2];
    logic            mv [2];
    logic            kl [2];
    logic [4:0]      ard [2];
    logic [4:0]      mrd [2];
    logic [XLEN-1:0] ares [2];
    logic [XLEN-1:0] mres [2];
    logic            stall [2];
    logic            wv [2];
    logic            we [2];
    logic            src [2];
    logic            ovf [2];
    logic [4:0]      wrd [2];
    logic [XLEN-1:0] wres [2];
    logic [1:0]      cnt0;
    logic [2:0]      cnt1;

    int total = 0;
    int bad   = 0;

    scalar_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(2)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn), .kill_i(kl[0]),
        .arith_valid_i(av[0]), .arith_rd_i(ard[0]), .arith_result_i(ares[0]),
        .mul_div_valid_i(mv[0]), .mul_div_rd_i(mrd[0]), .mul_div_result_i(mres[0]),
        .stall_o(stall[0]), .wb_valid_o(wv[0]), .wb_we_o(we[0]), .wb_rd_o(wrd[0]),
        .wb_result_o(wres[0]), .wb_src_o(src[0]), .fifo_count_o(cnt0), .overflow_o(ovf[0])
    );

    scalar_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(4)) u_dut4 (
        .clk_i(clk), .rstn_i(rstn), .kill_i(kl[1]),
        .arith_valid_i(av[1]), .arith_rd_i(ard[1]), .arith_result_i(ares[1]),
        .mul_div_valid_i(mv[1]), .mul_div_rd_i(mrd[1]), .mul_div_result_i(mres[1]),
        .stall_o(stall[1]), .wb_valid_o(wv[1]), .wb_we_o(we[1]), .wb_rd_o(wrd[1]),
        .wb_result_o(wres[1]), .wb_src_o(src[1]), .fifo_count_o(cnt1), .overflow_o(ovf[1])
    );

    typedef struct {
        logic            a_v;
        logic [4:0]      a_rd;
        logic [XLEN-1:0] a_res;
        logic            m_v;
        logic [4:0]      m_rd;
        logic [XLEN-1:0] m_res;
        logic            kill;
        logic            e_v;
        logic            e_we;
        logic [4:0]      e_rd;
        logic [XLEN-1:0] e_res;
        logic            e_src;
        int              e_cnt;
        logic            e_stall;
        logic            e_ovf;
    } vec_t;

    vec_t tv [$];

    function automatic int cnt_of(input int d);
        return (d == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic a, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                          input logic m, input logic [4:0] mr, input logic [XLEN-1:0] md, input logic k);
        av[d] = a; ard[d] = ar; ares[d] = ad;
        mv[d] = m; mrd[d] = mr; mres[d] = md;
        kl[d] = k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic a, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                       input logic m, input logic [4:0] mr, input logic [XLEN-1:0] md, input logic k,
                       input logic ev, input logic ewe, input logic [4:0] erd, input logic [XLEN-1:0] eres,
                       input logic esrc, input int ecnt, input logic estall, input logic eovf);
        vec_t v;
        v.a_v = a; v.a_rd = ar; v.a_res = ad; v.m_v = m; v.m_rd = mr; v.m_res = md; v.kill = k;
        v.e_v = ev; v.e_we = ewe; v.e_rd = erd; v.e_res = eres; v.e_src = esrc;
        v.e_cnt = ecnt; v.e_stall = estall; v.e_ovf = eovf;
        tv.push_back(v);
    endtask

    task automatic soak(input int d, input int n);
        logic [68:0]     q [$];
        logic [68:0]     head;
        logic            a_v, m_v, p_md, ev;
        logic [4:0]      a_rd, m_rd, p_rd;
        logic [XLEN-1:0] a_res, m_res, p_res;
        for (int c = 0; c < n + 12; c++) begin
            a_v   = (c < n) && !stall[d] && ($urandom_range(0, 99) < 60);
            m_v   = (c < n) && ($urandom_range(0, 99) < 40);
            a_rd  = 5'($urandom_range(0, 31));
            m_rd  = 5'($urandom_range(0, 31));
            a_res = {$urandom, $urandom};
            m_res = {$urandom, $urandom};
            set_in(d, a_v, a_rd, a_res, m_v, m_rd, m_res, 1'b0);
            if (a_v) q.push_back({a_rd, a_res});
            p_md = m_v; p_rd = m_rd; p_res = m_res;
            ev = m_v || (q.size() > 0);
            step();
            chk($sformatf("soak%0d c%0d valid", d, c), wv[d], ev);
            if (p_md) begin
                chk($sformatf("soak%0d c%0d md src", d, c), src[d], 1'b1);
                chk($sformatf("soak%0d c%0d md rd", d, c), wrd[d], p_rd);
                chk($sformatf("soak%0d c%0d md data", d, c), wres[d], p_res);
                chk($sformatf("soak%0d c%0d md we", d, c), we[d], p_rd != 5'd0);
            end else if (ev) begin
                head = q.pop_front();
                chk($sformatf("soak%0d c%0d ar src", d, c), src[d], 1'b0);
                chk($sformatf("soak%0d c%0d ar rd", d, c), wrd[d], head[68:64]);
                chk($sformatf("soak%0d c%0d ar data", d, c), wres[d], head[63:0]);
                chk($sformatf("soak%0d c%0d ar we", d, c), we[d], head[68:64] != 5'd0);
            end
        end
        chk($sformatf("soak%0d leftover", d), q.size(), 0);
        chk($sformatf("soak%0d overflow", d), ovf[d], 1'b0);
        set_in(d, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) set_in(d, 0, 0, 0, 0, 0, 0, 0);

        //   a  ard  ares      m  mrd  mres     k   v we rd  res       src cnt st ov
        add(0, 0,  0,         0, 0,  0,        0,  0, 0, 0,  0,        0,  0, 0, 0);
        add(1, 5,  'h1234,    0, 0,  0,        0,  1, 1, 5,  'h1234,   0,  0, 0, 0);
        add(1, 3,  'hA,       1, 4,  'hB,      0,  1, 1, 4,  'hB,      1,  1, 0, 0);
        add(0, 0,  0,         0, 0,  0,        0,  1, 1, 3,  'hA,      0,  0, 0, 0);
        add(0, 0,  0,         0, 0,  0,        0,  0, 0, 0,  0,        0,  0, 0, 0);
        add(1, 7,  'h71,      1, 6,  'h60,     0,  1, 1, 6,  'h60,     1,  1, 0, 0);
        add(1, 9,  'h92,      1, 8,  'h80,     0,  1, 1, 8,  'h80,     1,  2, 1, 0);
        add(0, 0,  0,         1, 10, 'hA0,     0,  1, 1, 10, 'hA0,     1,  2, 1, 0);
        add(0, 0,  0,         0, 0,  0,        0,  1, 1, 7,  'h71,     0,  1, 0, 0);
        add(0, 0,  0,         0, 0,  0,        0,  1, 1, 9,  'h92,     0,  0, 0, 0);
        add(1, 2,  'h22,      1, 1,  'h11,     0,  1, 1, 1,  'h11,     1,  1, 0, 0);
        add(1, 12, 'h44,      1, 11, 'h33,     0,  1, 1, 11, 'h33,     1,  2, 1, 0);
        add(1, 14, 'h66,      1, 13, 'h55,     0,  1, 1, 13, 'h55,     1,  2, 1, 1);
        add(0, 0,  0,         0, 0,  0,        0,  1, 1, 2,  'h22,     0,  1, 0, 1);
        add(0, 0,  0,         0, 0,  0,        0,  1, 1, 12, 'h44,     0,  0, 0, 1);
        add(0, 0,  0,         0, 0,  0,        0,  0, 0, 0,  0,        0,  0, 0, 1);
        add(1, 16, 'h88,      1, 15, 'h77,     0,  1, 1, 15, 'h77,     1,  1, 0, 1);
        add(1, 18, 'hAA,      1, 17, 'h99,     0,  1, 1, 17, 'h99,     1,  2, 1, 1);
        add(1, 19, 'hBB,      0, 0,  0,        1,  0, 0, 0,  0,        0,  0, 0, 1);
        add(0, 0,  0,         0, 0,  0,        0,  0, 0, 0,  0,        0,  0, 0, 1);
        add(1, 0,  'hFF,      0, 0,  0,        0,  1, 0, 0,  'hFF,     0,  0, 0, 1);
        add(0, 0,  0,         1, 0,  'h5,      0,  1, 0, 0,  'h5,      1,  0, 0, 1);
        add(1, 21, 'h210,     1, 20, 'h200,    0,  1, 1, 20, 'h200,    1,  1, 0, 1);
        add(1, 22, 'h220,     0, 0,  0,        0,  1, 1, 21, 'h210,    0,  1, 0, 1);
        add(0, 0,  0,         0, 0,  0,        0,  1, 1, 22, 'h220,    0,  0, 0, 1);

        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d valid", d), wv[d], 1'b0);
            chk($sformatf("rst%0d we", d), we[d], 1'b0);
            chk($sformatf("rst%0d src", d), src[d], 1'b0);
            chk($sformatf("rst%0d stall", d), stall[d], 1'b0);
            chk($sformatf("rst%0d ovf", d), ovf[d], 1'b0);
            chk($sformatf("rst%0d rd", d), wrd[d], 5'd0);
            chk($sformatf("rst%0d data", d), wres[d], 64'd0);
            chk($sformatf("rst%0d count", d), cnt_of(d), 0);
        end
        rstn = 1'b1;
        step();

        foreach (tv[i]) begin
            set_in(0, tv[i].a_v, tv[i].a_rd, tv[i].a_res, tv[i].m_v, tv[i].m_rd, tv[i].m_res, tv[i].kill);
            step();
            chk($sformatf("vec%0d valid", i), wv[0], tv[i].e_v);
            chk($sformatf("vec%0d we", i), we[0], tv[i].e_we);
            chk($sformatf("vec%0d src", i), src[0], tv[i].e_src);
            chk($sformatf("vec%0d count", i), cnt_of(0), tv[i].e_cnt);
            chk($sformatf("vec%0d stall", i), stall[0], tv[i].e_stall);
            chk($sformatf("vec%0d ovf", i), ovf[0], tv[i].e_ovf);
            if (tv[i].e_v) begin
                chk($sformatf("vec%0d rd", i), wrd[0], tv[i].e_rd);
                chk($sformatf("vec%0d data", i), wres[0], tv[i].e_res);
            end
        end

        // Asynchronous reset with a full FIFO: nothing buffered may ever be written back.
        set_in(0, 1, 2, 'hC2, 1, 1, 'hC1, 0);
        step();
        set_in(0, 1, 4, 'hC4, 1, 3, 'hC3, 0);
        step();
        chk("midrst pre count", cnt_of(0), 2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        chk("midrst valid", wv[0], 1'b0);
        chk("midrst count", cnt_of(0), 0);
        chk("midrst stall", stall[0], 1'b0);
        chk("midrst ovf", ovf[0], 1'b0);
        chk("midrst data", wres[0], 64'd0);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("postrst%0d valid", c), wv[0], 1'b0);
        end

        soak(0, 5000);
        soak(1, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
# scalar_wb_arbiter

- Merges the two scalar result streams leaving the execute stage into the single integer register-file write port of the writeback stage.
- The two streams are the arith result (ALU/branch, one per cycle) and the mul_div result (multi-cycle, cannot be back-pressured).
- The mul_div stream always wins; colliding arith results are buffered in a small in-order FIFO.
- When that FIFO is full, the arbiter stalls the execute stage.

## Interface
Parameters:
- XLEN, 64, data width of results
- FIFO_DEPTH, 2, arith buffer entries; power of two, >= 2

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- kill_i  in  1  pipeline flush, synchronous
- arith_valid_i  in  1  arith result valid
- arith_rd_i  in  5  arith destination register
- arith_result_i  in  XLEN  arith result data
- mul_div_valid_i  in  1  mul_div result valid
- mul_div_rd_i  in  5  mul_div destination register
- mul_div_result_i  in  XLEN  mul_div result data
- stall_o  out  1  arith FIFO full; execute stage must not present arith_valid_i
- wb_valid_o  out  1  writeback slot valid
- wb_we_o  out  1  register-file write enable (wb_valid_o and wb_rd_o != 0)
- wb_rd_o  out  5  writeback destination
- wb_result_o  out  XLEN  writeback data
- wb_src_o  out  1  0 = arith, 1 = mul_div
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current arith FIFO occupancy
- overflow_o  out  1  sticky: arith_valid_i seen while stall_o high

## Operation
- One writeback per cycle. Selection each cycle, highest priority first:
  - mul_div_valid_i: selected.
  - Else FIFO non-empty: pop the head and select it.
  - Else arith_valid_i: bypass, selected directly.
- arith_valid_i not selected that cycle (mul_div won, or FIFO non-empty) is pushed to the FIFO tail.
- Arith results retire in arrival order; a new arith never overtakes a buffered one.
- Push and pop in the same cycle are allowed. Count is unchanged and the pointers both advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is tracked separately and distinguishes full from empty.
- stall_o = (count == FIFO_DEPTH), combinational from the registered count.
- arith_valid_i while stall_o is high is a protocol violation:
  - the input is dropped;
  - overflow_o sets and stays set until reset;
  - FIFO contents and count are unchanged.
- rd == 0: the slot is still consumed (wb_valid_o=1, wb_we_o=0). The data is passed through unchanged.
- kill_i, effective at the next edge:
  - FIFO is emptied (pointers and count to 0);
  - the output register is cleared (wb_valid_o=0);
  - all inputs presented in the kill cycle are discarded;
  - overflow_o is not cleared.
- No state machine beyond the FIFO. The arbitration is combinational into a single output register.

## Timing
- Reset (asynchronous assert, synchronous release by design):
  - wb_valid_o, wb_we_o, wb_src_o, stall_o, overflow_o = 0;
  - wb_rd_o = 0, wb_result_o = 0;
  - fifo_count_o = 0; pointers = 0.
- Outputs wb_* are registered: a result selected in cycle N appears on wb_* in cycle N+1.
- Latencies:
  - bypass arith and mul_div: 1 cycle;
  - buffered arith: 1 + (cycles spent in FIFO).
- Worst case: FIFO_DEPTH back-to-back mul_div collisions fill the FIFO. stall_o rises in the cycle after the filling push.
- stall_o falls in the cycle after the first pop that takes count below FIFO_DEPTH.
- wb_valid_o is low in any cycle with no selection. It is never held from the previous cycle.
- Reset mid-operation discards all buffered results immediately, with no writeback.

## Test plan
- Bypass:
  - stimulus: arith x5 = 0x1234 for one cycle, no mul_div;
  - response: next cycle wb_valid_o=1, wb_we_o=1, wb_rd_o=5, wb_result_o=0x1234, wb_src_o=0; count stays 0.
- Collision:
  - stimulus: same cycle arith (x3, 0xA) and mul_div (x4, 0xB);
  - response: cycle+1 writes x4/0xB src=1; cycle+2 writes x3/0xA src=0; count shows 1 for one cycle.
- Ordering and full, DEPTH=2:
  - stimulus: mul_div valid 3 cycles with arith valid in the first 2 cycles (a1, a2);
  - response: stall_o=1 after the second push; then a1 and a2 written in order on the two cycles after mul_div ends; stall_o drops after the a1 pop.
- Overflow:
  - stimulus: with FIFO full and mul_div valid, drive arith_valid_i;
  - response: entry dropped, overflow_o=1 and sticky, count stays 2, subsequent drain order intact.
- Kill and rd==0:
  - stimulus: FIFO holding 2 entries, kill_i pulsed together with arith valid;
  - response: next cycle count=0, wb_valid_o=0, no buffered or in-kill result ever written.
  - stimulus: arith x0 = 0xFF;
  - response: wb_valid_o=1, wb_we_o=0.
- Random soak:
  - stimulus: 10k cycles of random mul_div and arith (arith gated by stall_o), random rd/data, DEPTH=2 and 4;
  - response: scoreboard confirms every mul_div result written 1 cycle later, arith results complete and in order, at most one write per cycle, overflow_o=0.
